// File: rtl/trap_controller_pkg.sv
`default_nettype none
// ==========================================================================
// trap_controller_pkg : shared types and cause constants for trap sequencing
// Revision : 1.0
// ==========================================================================
package trap_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FIRE   = 2'd2,
      ST_SETTLE = 2'd3
   } trap_state_t;

   typedef enum logic {
      KIND_TRAP = 1'b0,
      KIND_MRET = 1'b1
   } trap_kind_t;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_M = 2'd3;

   localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
   localparam logic [3:0] EXC_INST_FAULT     = 4'd1;
   localparam logic [3:0] EXC_ILLEGAL_INST   = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
   localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
   localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
   localparam logic [3:0] EXC_ECALL_U        = 4'd8;
   localparam logic [3:0] EXC_ECALL_S        = 4'd9;
   localparam logic [3:0] EXC_ECALL_M        = 4'd11;

   localparam logic [31:0] IRQ_MTI_CAUSE = 32'h8000_0007;

   // The pipeline reports every ecall as code 11; the privilege decides the real cause.
   function automatic logic [31:0] exc_cause(input logic [3:0] code, input logic [1:0] priv);
      if (code == EXC_ECALL_M && priv == PRIV_U)
         return {28'b0, EXC_ECALL_U};
      return {28'b0, code};
   endfunction

endpackage
`default_nettype wire

// File: rtl/trap_controller_priority_enc.sv
`default_nettype none
// ==========================================================================
// trap_priority_enc : combinational event selection and trap record build
// Revision : 1.0
// ==========================================================================
module trap_priority_enc
   import trap_controller_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            in_idle,
   input  logic            in_drain,
   input  logic            irq,
   input  logic            mem_busy,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            exc_valid,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   input  logic [1:0]      priv_mode,
   output logic            accept,
   output logic            drain_req,
   output trap_kind_t      kind,
   output logic [31:0]     cause,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     tval
);

   logic sync_evt;

   always_comb begin
      kind  = KIND_TRAP;
      cause = 32'd0;
      pc    = commit_pc;
      tval  = 32'd0;
      if (irq) begin
         cause = IRQ_MTI_CAUSE;
         pc    = commit_valid ? commit_pc : fetch_pc;
      end else if (exc_valid) begin
         cause = exc_cause(exc_code, priv_mode);
         tval  = 32'(exc_tval);
      end else if (mret_valid && priv_mode == PRIV_U) begin
         cause = {28'b0, EXC_ILLEGAL_INST};
      end else if (mret_valid) begin
         kind = KIND_MRET;
      end
   end

   assign sync_evt = exc_valid | mret_valid;

   // Interrupts wait out an in-flight bus access; synchronous events never do.
   assign accept    = (in_idle  & (irq ? ~mem_busy : sync_evt))
                    | (in_drain & irq & ~mem_busy);
   assign drain_req = in_idle & irq & mem_busy;

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ==========================================================================
// trap_controller : sequences machine-mode trap entry, mret and timer irq
// Revision : 1.0
// ==========================================================================
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            exc_valid,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   input  logic            mem_busy,
   input  logic            mtip,
   input  logic            mstatus_mie,
   input  logic            mie_mtie,
   input  logic [1:0]      priv_mode,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic [XLEN-1:0] mepc_in,
   output logic            commit_kill,
   output logic            stall_req,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_enter,
   output logic [31:0]     trap_cause,
   output logic [XLEN-1:0] trap_pc,
   output logic [31:0]     trap_val,
   output logic            mret_exec
);

   trap_state_t     state_q, state_d;
   logic [1:0]      settle_cnt_q, settle_cnt_d;
   logic            stall_q, stall_d;
   logic            flush_q, flush_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            trap_enter_q, trap_enter_d;
   logic            mret_exec_q, mret_exec_d;
   logic [31:0]     trap_cause_q, trap_cause_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d;
   logic [31:0]     trap_val_q, trap_val_d;

   logic            irq, accept, drain_req;
   trap_kind_t      enc_kind;
   logic [31:0]     enc_cause, enc_tval;
   logic [XLEN-1:0] enc_pc;

   assign irq = mtip & mie_mtie & ((priv_mode == PRIV_U) | mstatus_mie);

   trap_priority_enc #(.XLEN(XLEN)) u_enc (
      .in_idle      (state_q == ST_IDLE),
      .in_drain     (state_q == ST_DRAIN),
      .irq          (irq),
      .mem_busy     (mem_busy),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .fetch_pc     (fetch_pc),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code),
      .exc_tval     (exc_tval),
      .mret_valid   (mret_valid),
      .priv_mode    (priv_mode),
      .accept       (accept),
      .drain_req    (drain_req),
      .kind         (enc_kind),
      .cause        (enc_cause),
      .pc           (enc_pc),
      .tval         (enc_tval)
   );

   always_comb begin
      state_d          = state_q;
      settle_cnt_d     = settle_cnt_q;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      trap_enter_d     = 1'b0;
      mret_exec_d      = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      trap_cause_d     = trap_cause_q;
      trap_pc_d        = trap_pc_q;
      trap_val_d       = trap_val_q;

      case (state_q)
         ST_IDLE: begin
            if (accept)         state_d = ST_FIRE;
            else if (drain_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (accept)         state_d = ST_FIRE;
            else if (!irq)      state_d = ST_IDLE;
         end
         ST_FIRE: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = 2'(SETTLE_CYCLES - 1);
         end
         default: begin
            if (settle_cnt_q == 2'd0) state_d = ST_IDLE;
            else                      settle_cnt_d = settle_cnt_q - 2'd1;
         end
      endcase

      // FIRE strobes and the trap record are captured at accept so they are stable in FIRE.
      if (accept) begin
         flush_d          = 1'b1;
         redirect_valid_d = 1'b1;
         if (enc_kind == KIND_TRAP) begin
            trap_enter_d  = 1'b1;
            redirect_pc_d = mtvec_in;
            trap_cause_d  = enc_cause;
            trap_pc_d     = enc_pc;
            trap_val_d    = enc_tval;
         end else begin
            mret_exec_d   = 1'b1;
            redirect_pc_d = mepc_in;
         end
      end

      stall_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         settle_cnt_q     <= 2'd0;
         stall_q          <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         trap_enter_q     <= 1'b0;
         mret_exec_q      <= 1'b0;
         trap_cause_q     <= 32'd0;
         trap_pc_q        <= '0;
         trap_val_q       <= 32'd0;
      end else begin
         state_q          <= state_d;
         settle_cnt_q     <= settle_cnt_d;
         stall_q          <= stall_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         trap_enter_q     <= trap_enter_d;
         mret_exec_q      <= mret_exec_d;
         trap_cause_q     <= trap_cause_d;
         trap_pc_q        <= trap_pc_d;
         trap_val_q       <= trap_val_d;
      end
   end

   assign commit_kill    = accept & commit_valid;
   assign stall_req      = stall_q | accept | drain_req;
   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign trap_enter     = trap_enter_q;
   assign mret_exec      = mret_exec_q;
   assign trap_cause     = trap_cause_q;
   assign trap_pc        = trap_pc_q;
   assign trap_val       = trap_val_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ==========================================================================
// tb_trap_controller : directed and randomized checks of trap_controller
// Revision : 1.0
// ==========================================================================
module tb_trap_controller;

   localparam int XLEN = 32;
   localparam int SC   = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            commit_valid, exc_valid, mret_valid, mem_busy;
   logic            mtip, mstatus_mie, mie_mtie;
   logic [XLEN-1:0] commit_pc, fetch_pc, exc_tval, mtvec_in, mepc_in;
   logic [3:0]      exc_code;
   logic [1:0]      priv_mode;
   logic            commit_kill, stall_req, flush, redirect_valid, trap_enter, mret_exec;
   logic [XLEN-1:0] redirect_pc, trap_pc;
   logic [31:0]     trap_cause, trap_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trap_controller #(.XLEN(XLEN), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .fetch_pc(fetch_pc),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .mem_busy(mem_busy), .mtip(mtip),
      .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .priv_mode(priv_mode),
      .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .commit_kill(commit_kill), .stall_req(stall_req), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_enter(trap_enter), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_val(trap_val), .mret_exec(mret_exec)
   );

   typedef struct {
      bit        take;
      bit        is_mret;
      bit [31:0] cause;
      bit [31:0] pc;
      bit [31:0] tval;
   } exp_t;

   // Expected outcome for the current inputs when the controller is idle and the bus is quiet.
   function automatic exp_t model();
      exp_t e;
      bit   irq_on;
      e = '{default: 0};
      irq_on = mtip && mie_mtie && (priv_mode == 2'd0 || mstatus_mie);
      if (irq_on) begin
         e.take = 1; e.cause = 32'h8000_0007;
         e.pc = commit_valid ? commit_pc : fetch_pc;
      end else if (exc_valid) begin
         e.take = 1; e.pc = commit_pc; e.tval = exc_tval;
         e.cause = (exc_code == 4'd11 && priv_mode == 2'd0) ? 32'd8 : {28'd0, exc_code};
      end else if (mret_valid) begin
         e.take = 1; e.pc = commit_pc;
         if (priv_mode == 2'd0) e.cause = 32'd2;
         else                   e.is_mret = 1;
      end
      return e;
   endfunction

   task automatic clear_inputs();
      commit_valid = 0; exc_valid = 0; mret_valid = 0; mem_busy = 0;
      mtip = 0; mstatus_mie = 0; mie_mtie = 0; priv_mode = 2'd3;
      commit_pc = '0; fetch_pc = '0; exc_code = '0; exc_tval = '0;
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({stall_req, flush, redirect_valid, trap_enter, mret_exec, commit_kill} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000000",
            {stall_req, flush, redirect_valid, trap_enter, mret_exec, commit_kill});
      end
      checks++;
      if ({redirect_pc, trap_cause, trap_pc, trap_val} !== 128'd0) begin
         errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
            redirect_pc, trap_cause, trap_pc, trap_val);
      end
      @(negedge clk); rst = 0;
      mtip = 1; mie_mtie = 1; mstatus_mie = 1; mem_busy = 1; commit_valid = 1; commit_pc = 32'h300;
      @(negedge clk); #1;
      checks++;
      if (stall_req !== 1'b1) begin
         errors++; $display("FAIL drain_stall_pre_reset: got %b expected 1", stall_req);
      end
      rst = 1; clear_inputs(); #1;
      checks++;
      if ({stall_req, flush, redirect_valid, trap_enter, mret_exec, commit_kill} !== 6'b0) begin
         errors++; $display("FAIL reset_mid_drain: got %b expected 000000",
            {stall_req, flush, redirect_valid, trap_enter, mret_exec, commit_kill});
      end
      @(negedge clk); rst = 0;
      @(negedge clk); #1;
      checks++;
      if ({trap_enter, stall_req} !== 2'b00) begin
         errors++; $display("FAIL post_reset_idle: got %b expected 00", {trap_enter, stall_req});
      end
   endtask

   task automatic test_exception();
      @(negedge clk);
      priv_mode = 2'd3; commit_valid = 1; commit_pc = 32'h100; exc_valid = 1;
      exc_code = 4'd2; exc_tval = 32'hDEAD; mtvec_in = 32'h800;
      #1;
      checks++;
      if ({commit_kill, stall_req, trap_enter} !== 3'b110) begin
         errors++; $display("FAIL exc_accept: got %b expected 110", {commit_kill, stall_req, trap_enter});
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({trap_enter, mret_exec, flush, redirect_valid, stall_req} !== 5'b10111) begin
         errors++; $display("FAIL exc_fire_ctrl: got %b expected 10111",
            {trap_enter, mret_exec, flush, redirect_valid, stall_req});
      end
      checks++;
      if ({redirect_pc, trap_cause, trap_pc, trap_val} !== {32'h800, 32'h2, 32'h100, 32'hDEAD}) begin
         errors++; $display("FAIL exc_fire_data: got %h/%h/%h/%h expected 800/2/100/dead",
            redirect_pc, trap_cause, trap_pc, trap_val);
      end
      @(negedge clk); #1;
      checks++;
      if ({stall_req, flush, redirect_valid, trap_enter} !== 4'b1000) begin
         errors++; $display("FAIL exc_settle: got %b expected 1000",
            {stall_req, flush, redirect_valid, trap_enter});
      end
      @(negedge clk); #1;
      checks++;
      if (stall_req !== 1'b0) begin
         errors++; $display("FAIL exc_back_idle: got %b expected 0", stall_req);
      end
   endtask

   task automatic test_ecall();
      logic [1:0]  privs [2];
      logic [31:0] want  [2];
      privs[0] = 2'd0; want[0] = 32'h8;
      privs[1] = 2'd3; want[1] = 32'hB;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         priv_mode = privs[i]; commit_valid = 1; commit_pc = 32'h40 + i;
         exc_valid = 1; exc_code = 4'd11; exc_tval = 32'h0;
         @(negedge clk); clear_inputs(); #1;
         checks++;
         if ({trap_enter, trap_cause} !== {1'b1, want[i]}) begin
            errors++; $display("FAIL ecall_cause priv=%0d: got %b/%h expected 1/%h",
               privs[i], trap_enter, trap_cause, want[i]);
         end
         repeat (SC + 1) @(negedge clk);
      end
   endtask

   task automatic test_irq_drain();
      @(negedge clk);
      mtip = 1; mie_mtie = 1; mstatus_mie = 1; priv_mode = 2'd3;
      mem_busy = 1; commit_valid = 1; commit_pc = 32'h200; fetch_pc = 32'h204;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({stall_req, commit_kill, trap_enter} !== 3'b100) begin
            errors++; $display("FAIL irq_drain_hold cyc=%0d: got %b expected 100",
               i, {stall_req, commit_kill, trap_enter});
         end
         @(negedge clk);
      end
      mem_busy = 0; #1;
      checks++;
      if ({commit_kill, stall_req} !== 2'b11) begin
         errors++; $display("FAIL irq_drain_accept: got %b expected 11", {commit_kill, stall_req});
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({trap_enter, trap_cause, trap_pc, trap_val} !== {1'b1, 32'h8000_0007, 32'h200, 32'h0}) begin
         errors++; $display("FAIL irq_fire: got %b/%h/%h/%h expected 1/80000007/200/0",
            trap_enter, trap_cause, trap_pc, trap_val);
      end
      repeat (SC + 1) @(negedge clk);
   endtask

   task automatic test_irq_enable();
      @(negedge clk);
      mtip = 1; mie_mtie = 1; mstatus_mie = 0; priv_mode = 2'd3; fetch_pc = 32'h500;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({stall_req, trap_enter} !== 2'b00) begin
            errors++; $display("FAIL irq_masked_m cyc=%0d: got %b expected 00", i, {stall_req, trap_enter});
         end
         @(negedge clk);
      end
      priv_mode = 2'd0; #1;
      checks++;
      if ({stall_req, commit_kill} !== 2'b10) begin
         errors++; $display("FAIL irq_umode_accept: got %b expected 10", {stall_req, commit_kill});
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({trap_enter, trap_pc} !== {1'b1, 32'h500}) begin
         errors++; $display("FAIL irq_umode_fire: got %b/%h expected 1/500", trap_enter, trap_pc);
      end
      repeat (SC + 1) @(negedge clk);
   endtask

   task automatic test_irq_vs_exc();
      @(negedge clk);
      mtip = 1; mie_mtie = 1; mstatus_mie = 1; commit_valid = 1; commit_pc = 32'h600;
      exc_valid = 1; exc_code = 4'd5; exc_tval = 32'hBEEF; #1;
      checks++;
      if (commit_kill !== 1'b1) begin
         errors++; $display("FAIL irq_exc_kill: got %b expected 1", commit_kill);
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({trap_cause, trap_val, trap_pc} !== {32'h8000_0007, 32'h0, 32'h600}) begin
         errors++; $display("FAIL irq_exc_fire: got %h/%h/%h expected 80000007/0/600",
            trap_cause, trap_val, trap_pc);
      end
      repeat (SC + 1) @(negedge clk);
      mtip = 1; mie_mtie = 1; mstatus_mie = 1; mem_busy = 1;
      @(negedge clk);
      mtip = 0; commit_valid = 1; commit_pc = 32'h700; exc_valid = 1; exc_code = 4'd7; exc_tval = 32'h77;
      #1;
      checks++;
      if ({stall_req, commit_kill} !== 2'b10) begin
         errors++; $display("FAIL irq_drop_drain: got %b expected 10", {stall_req, commit_kill});
      end
      @(negedge clk); #1;
      checks++;
      if ({trap_enter, commit_kill} !== 2'b01) begin
         errors++; $display("FAIL irq_drop_exc_accept: got %b expected 01", {trap_enter, commit_kill});
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({trap_enter, trap_cause, trap_pc} !== {1'b1, 32'h7, 32'h700}) begin
         errors++; $display("FAIL irq_drop_exc_fire: got %b/%h/%h expected 1/7/700",
            trap_enter, trap_cause, trap_pc);
      end
      repeat (SC + 1) @(negedge clk);
   endtask

   task automatic test_mret();
      @(negedge clk);
      priv_mode = 2'd3; commit_valid = 1; commit_pc = 32'h900; mret_valid = 1;
      mepc_in = 32'h104; mtvec_in = 32'h800;
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({mret_exec, trap_enter, flush, redirect_valid, redirect_pc} !== {4'b1011, 32'h104}) begin
         errors++; $display("FAIL mret_m: got %b/%h expected 1011/104",
            {mret_exec, trap_enter, flush, redirect_valid}, redirect_pc);
      end
      repeat (SC + 1) @(negedge clk);
      priv_mode = 2'd0; commit_valid = 1; commit_pc = 32'h904; mret_valid = 1;
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if ({mret_exec, trap_enter, trap_cause, trap_val, redirect_pc} !== {2'b01, 32'h2, 32'h0, 32'h800}) begin
         errors++; $display("FAIL mret_u: got %b/%h/%h/%h expected 01/2/0/800",
            {mret_exec, trap_enter}, trap_cause, trap_val, redirect_pc);
      end
      repeat (SC + 1) @(negedge clk);
   endtask

   task automatic test_random();
      exp_t e;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         priv_mode    = ($urandom_range(1) == 1) ? 2'd3 : 2'd0;
         mstatus_mie  = 1'($urandom_range(1));
         mie_mtie     = 1'($urandom_range(1));
         mtip         = ($urandom_range(3) == 0);
         mem_busy     = 0;
         commit_valid = 1'($urandom_range(1));
         exc_valid    = commit_valid & 1'($urandom_range(1));
         mret_valid   = commit_valid & ($urandom_range(2) == 0);
         exc_code     = 4'($urandom_range(11));
         commit_pc    = $urandom; fetch_pc = $urandom; exc_tval = $urandom;
         mtvec_in     = $urandom; mepc_in  = $urandom;
         e = model();
         #1;
         checks++;
         if ({commit_kill, stall_req, trap_enter, mret_exec, flush} !== {e.take & commit_valid, e.take, 3'b000}) begin
            errors++; $display("FAIL rand_accept n=%0d: got %b expected %b", n,
               {commit_kill, stall_req, trap_enter, mret_exec, flush},
               {e.take & commit_valid, e.take, 3'b000});
         end
         if (e.take) begin
            @(negedge clk);
            commit_valid = 1; exc_valid = 1; mret_valid = 1; mtip = 0;
            #1;
            checks++;
            if ({trap_enter, mret_exec, flush, redirect_valid, redirect_pc} !==
                {!e.is_mret, e.is_mret, 2'b11, (e.is_mret ? mepc_in : mtvec_in)}) begin
               errors++; $display("FAIL rand_fire n=%0d: got %b/%h mret=%0d", n,
                  {trap_enter, mret_exec, flush, redirect_valid}, redirect_pc, e.is_mret);
            end
            if (!e.is_mret) begin
               checks++;
               if ({trap_cause, trap_pc, trap_val} !== {e.cause, e.pc, e.tval}) begin
                  errors++; $display("FAIL rand_record n=%0d: got %h/%h/%h expected %h/%h/%h", n,
                     trap_cause, trap_pc, trap_val, e.cause, e.pc, e.tval);
               end
            end
            for (int s = 0; s < SC; s++) begin
               @(negedge clk); #1;
               checks++;
               if ({stall_req, commit_kill, trap_enter, mret_exec, flush} !== 5'b10000) begin
                  errors++; $display("FAIL rand_settle n=%0d: got %b expected 10000", n,
                     {stall_req, commit_kill, trap_enter, mret_exec, flush});
               end
            end
            @(negedge clk); clear_inputs(); #1;
            checks++;
            if (stall_req !== 1'b0) begin
               errors++; $display("FAIL rand_idle n=%0d: got %b expected 0", n, stall_req);
            end
         end
      end
   endtask

   initial begin
      rst = 1; mtvec_in = '0; mepc_in = '0;
      clear_inputs();
      test_reset();
      test_exception();
      test_ecall();
      test_irq_drain();
      test_irq_enable();
      test_irq_vs_exc();
      test_mret();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
